// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: register/address widths,
// writeback-select encoding, the zero register and the controller FSM states.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_WIDTH  = 5;
   localparam int INST_ADDR_WIDTH = 32;
   localparam int WB_SEL_WIDTH    = 2;

   localparam logic [WB_SEL_WIDTH-1:0]   WB_MEM   = 2'd1;
   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      PCTL_RUN      = 2'd0,
      PCTL_FLUSH    = 2'd1,
      PCTL_WAIT_MEM = 2'd2
   } pctl_state_e;

   // True when an enabled source register is the pending load destination.
   function automatic logic rs_hazard(input logic                      ren,
                                      input logic [REG_ADDR_WIDTH-1:0] rs,
                                      input logic [REG_ADDR_WIDTH-1:0] rd);
      return ren && (rs == rd);
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating event counter used for the optional pipeline performance counters.
// Only present when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush/redirect controller for the 4-stage core.
// Optional perf counters (stall_cnt_o, flush_cnt_o) are enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 255
`ifdef PIPE_CTRL_PERF_EN
   ,
   parameter int CNT_W        = 32
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [REG_ADDR_WIDTH-1:0]  id_rs1_raddr,
   input  logic [REG_ADDR_WIDTH-1:0]  id_rs2_raddr,
   input  logic                       id_rs1_ren,
   input  logic                       id_rs2_ren,
   input  logic [REG_ADDR_WIDTH-1:0]  ex_rd_waddr,
   input  logic [WB_SEL_WIDTH-1:0]    ex_wb_sel,
   input  logic                       jump_en_i,
   input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
   input  logic                       mem_busy_i,
   input  logic                       int_req_i,
   input  logic [INST_ADDR_WIDTH-1:0] int_addr_i,
   output logic                       hold_pc_o,
   output logic                       hold_if_o,
   output logic                       hold_id_o,
   output logic                       flush_if_o,
   output logic                       flush_id_o,
   output logic                       pc_we_o,
   output logic [INST_ADDR_WIDTH-1:0] pc_wdata_o,
   output logic                       int_ack_o,
   output logic                       timeout_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]           stall_cnt_o,
   output logic [CNT_W-1:0]           flush_cnt_o
`endif
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   pctl_state_e     state_q, state_d;
   logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            mem_blocked_q, mem_blocked_d;
   logic            load_use;
   logic            mem_busy_eff;
   logic            redirect;

   assign load_use = (ex_wb_sel == WB_MEM) && (ex_rd_waddr != ZERO_REG) &&
                     (rs_hazard(id_rs1_ren, id_rs1_raddr, ex_rd_waddr) ||
                      rs_hazard(id_rs2_ren, id_rs2_raddr, ex_rd_waddr));

   // After a timeout the same busy episode must not start a new wait.
   assign mem_busy_eff = mem_busy_i && !mem_blocked_q;

   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      mem_blocked_d = mem_blocked_q && mem_busy_i;
      redirect      = 1'b0;
      hold_pc_o     = 1'b0;
      hold_if_o     = 1'b0;
      hold_id_o     = 1'b0;
      flush_if_o    = 1'b0;
      flush_id_o    = 1'b0;
      pc_we_o       = 1'b0;
      pc_wdata_o    = '0;
      int_ack_o     = 1'b0;
      timeout_o     = 1'b0;
      if (!rst) begin
         unique case (state_q)
            PCTL_RUN: begin
               if (int_req_i && !mem_busy_eff) begin
                  redirect   = 1'b1;
                  pc_wdata_o = int_addr_i;
                  int_ack_o  = 1'b1;
               end else if (mem_busy_eff) begin
                  hold_pc_o  = 1'b1;
                  hold_if_o  = 1'b1;
                  hold_id_o  = 1'b1;
                  state_d    = PCTL_WAIT_MEM;
                  wait_cnt_d = WC_W'(1);
               end else if (jump_en_i) begin
                  redirect   = 1'b1;
                  pc_wdata_o = jump_addr_i;
               end else if (load_use) begin
                  hold_pc_o  = 1'b1;
                  hold_if_o  = 1'b1;
                  flush_id_o = 1'b1;
               end
               if (redirect) begin
                  pc_we_o    = 1'b1;
                  flush_if_o = 1'b1;
                  flush_id_o = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d     = PCTL_FLUSH;
                     flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                  end
               end
            end
            PCTL_FLUSH: begin
               flush_id_o = 1'b1;
               if (flush_cnt_q <= FC_W'(1)) begin
                  state_d     = PCTL_RUN;
                  flush_cnt_d = '0;
               end else begin
                  flush_cnt_d = flush_cnt_q - FC_W'(1);
               end
            end
            PCTL_WAIT_MEM: begin
               if (!mem_busy_i) begin
                  state_d    = PCTL_RUN;
                  wait_cnt_d = '0;
               end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
                  timeout_o     = 1'b1;
                  state_d       = PCTL_RUN;
                  wait_cnt_d    = '0;
                  mem_blocked_d = 1'b1;
               end else begin
                  hold_pc_o  = 1'b1;
                  hold_if_o  = 1'b1;
                  hold_id_o  = 1'b1;
                  wait_cnt_d = wait_cnt_q + WC_W'(1);
               end
            end
            default: state_d = PCTL_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= PCTL_RUN;
         flush_cnt_q   <= '0;
         wait_cnt_q    <= '0;
         mem_blocked_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_blocked_q <= mem_blocked_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (hold_pc_o | hold_if_o | hold_id_o),
      .cnt_o (stall_cnt_o)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (pc_we_o),
      .cnt_o (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: expected output vectors are queued
// as each cycle's stimulus is driven and popped/compared at the following negedge.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
   logic        id_rs1_ren, id_rs2_ren;
   logic [1:0]  ex_wb_sel;
   logic        jump_en_i, mem_busy_i, int_req_i;
   logic [31:0] jump_addr_i, int_addr_i;
   logic        hold_pc_o, hold_if_o, hold_id_o, flush_if_o, flush_id_o;
   logic        pc_we_o, int_ack_o, timeout_o;
   logic [31:0] pc_wdata_o;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_o, flush_cnt_o;
   int          stallModel = 0;
   int          flushModel = 0;
`endif

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic        ren1, ren2;
      logic [1:0]  wb;
      logic        jump;
      logic [31:0] jaddr;
      logic        busy;
      logic        irq;
      logic [31:0] iaddr;
   } stim_t;

   typedef struct {
      logic [39:0] vec;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   errCount   = 0;
   int   checkCount = 0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs1_raddr (id_rs1_raddr),
      .id_rs2_raddr (id_rs2_raddr),
      .id_rs1_ren   (id_rs1_ren),
      .id_rs2_ren   (id_rs2_ren),
      .ex_rd_waddr  (ex_rd_waddr),
      .ex_wb_sel    (ex_wb_sel),
      .jump_en_i    (jump_en_i),
      .jump_addr_i  (jump_addr_i),
      .mem_busy_i   (mem_busy_i),
      .int_req_i    (int_req_i),
      .int_addr_i   (int_addr_i),
      .hold_pc_o    (hold_pc_o),
      .hold_if_o    (hold_if_o),
      .hold_id_o    (hold_id_o),
      .flush_if_o   (flush_if_o),
      .flush_id_o   (flush_id_o),
      .pc_we_o      (pc_we_o),
      .pc_wdata_o   (pc_wdata_o),
      .int_ack_o    (int_ack_o),
      .timeout_o    (timeout_o)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cnt_o  (stall_cnt_o),
      .flush_cnt_o  (flush_cnt_o)
`endif
   );

   // Expected vector layout: {hold_pc, hold_if, hold_id, flush_if, flush_id, pc_we, int_ack, timeout, pc_wdata}
   function automatic logic [39:0] mkExp(input logic hpc, input logic hif, input logic hid,
                                         input logic fif, input logic fid, input logic we,
                                         input logic ack, input logic to, input logic [31:0] wdata);
      return {hpc, hif, hid, fif, fid, we, ack, to, wdata};
   endfunction

   function automatic stim_t idleStim();
      stim_t s;
      s.rs1 = 5'd0; s.rs2 = 5'd0; s.rd = 5'd0; s.ren1 = 1'b0; s.ren2 = 1'b0;
      s.wb = 2'd0; s.jump = 1'b0; s.jaddr = 32'h0; s.busy = 1'b0;
      s.irq = 1'b0; s.iaddr = 32'h0;
      return s;
   endfunction

   task automatic applyStimulus(input stim_t s, input logic [39:0] expVec, input string tag);
      id_rs1_raddr = s.rs1;
      id_rs2_raddr = s.rs2;
      ex_rd_waddr  = s.rd;
      id_rs1_ren   = s.ren1;
      id_rs2_ren   = s.ren2;
      ex_wb_sel    = s.wb;
      jump_en_i    = s.jump;
      jump_addr_i  = s.jaddr;
      mem_busy_i   = s.busy;
      int_req_i    = s.irq;
      int_addr_i   = s.iaddr;
      sb.push_back('{vec: expVec, tag: tag});
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [39:0] obs;
      @(negedge clk);
      obs = {hold_pc_o, hold_if_o, hold_id_o, flush_if_o, flush_id_o,
             pc_we_o, int_ack_o, timeout_o, pc_wdata_o};
      checkCount++;
      if (sb.size() == 0) begin
         errCount++;
         $error("[TB] FAIL scoreboard_empty observed=%h expected=queued_entry", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.vec) else begin
         errCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
      end
`ifdef PIPE_CTRL_PERF_EN
      if (rst) begin
         stallModel = 0;
         flushModel = 0;
      end
      checkCount++;
      assert (stall_cnt_o === 32'(stallModel)) else begin
         errCount++;
         $error("[TB] FAIL %s_stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt_o, stallModel);
      end
      checkCount++;
      assert (flush_cnt_o === 32'(flushModel)) else begin
         errCount++;
         $error("[TB] FAIL %s_flush_cnt observed=%0d expected=%0d", e.tag, flush_cnt_o, flushModel);
      end
      if (!rst) begin
         if (e.vec[39:37] != 3'b000) stallModel++;
         if (e.vec[34]) flushModel++;
      end
`endif
   endtask

   task automatic step(input stim_t s, input logic [39:0] expVec, input string tag);
      applyStimulus(s, expVec, tag);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   initial begin
      stim_t       s;
      logic [39:0] zero;
      logic [39:0] holdAll;
      logic [39:0] bubble;
      zero    = mkExp(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      holdAll = mkExp(1, 1, 1, 0, 0, 0, 0, 0, 32'h0);
      bubble  = mkExp(1, 1, 0, 0, 1, 0, 0, 0, 32'h0);

      // Reset: outputs stay low even with a jump and an interrupt requested.
      rst = 1'b1;
      s = idleStim(); s.jump = 1'b1; s.jaddr = 32'h1234_5678; s.irq = 1'b1; s.iaddr = 32'h40;
      step(s, zero, "reset_out");
      rst = 1'b0;

      step(idleStim(), zero, "idle");

      s = idleStim(); s.wb = WB_MEM; s.rd = 5'd5; s.rs1 = 5'd5; s.ren1 = 1'b1;
      step(s, bubble, "loaduse_rs1");
      s.wb = 2'd0;
      step(s, zero, "loaduse_clear");
      s = idleStim(); s.wb = WB_MEM; s.rd = 5'd0; s.rs1 = 5'd0; s.ren1 = 1'b1;
      step(s, zero, "loaduse_zero_reg");
      s = idleStim(); s.wb = WB_MEM; s.rd = 5'd5; s.rs1 = 5'd5; s.ren1 = 1'b0;
      step(s, zero, "loaduse_no_ren");
      s = idleStim(); s.wb = WB_MEM; s.rd = 5'd7; s.rs1 = 5'd3; s.rs2 = 5'd7; s.ren1 = 1'b1; s.ren2 = 1'b1;
      step(s, bubble, "loaduse_rs2");

      // Jump, then a second jump arriving during the flush must be ignored.
      s = idleStim(); s.jump = 1'b1; s.jaddr = 32'h8000_0100;
      step(s, mkExp(0, 0, 0, 1, 1, 1, 0, 0, 32'h8000_0100), "jump");
      s.jaddr = 32'h0000_1234;
      step(s, mkExp(0, 0, 0, 0, 1, 0, 0, 0, 32'h0), "jump_flush2");
      step(idleStim(), zero, "jump_done");

      s = idleStim(); s.busy = 1'b1;
      for (int i = 0; i < 10; i++) step(s, holdAll, "membusy");
      step(idleStim(), zero, "mem_release");
      step(idleStim(), zero, "mem_back_run");

      // Interrupt and jump together: interrupt wins; level request ignored during flush.
      s = idleStim(); s.irq = 1'b1; s.iaddr = 32'h0000_0040; s.jump = 1'b1; s.jaddr = 32'h8000_0200;
      step(s, mkExp(0, 0, 0, 1, 1, 1, 1, 0, 32'h0000_0040), "int_entry");
      s.jump = 1'b0;
      step(s, mkExp(0, 0, 0, 0, 1, 0, 0, 0, 32'h0), "int_flush");
      step(idleStim(), zero, "int_done");

      // Long memory wait: timeout pulse on busy cycle 255, then no re-wait until busy drops.
      s = idleStim(); s.busy = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         if (i < 255)       step(s, holdAll, "timeout_hold");
         else if (i == 255) step(s, mkExp(0, 0, 0, 0, 0, 0, 0, 1, 32'h0), "timeout_pulse");
         else               step(s, zero, "timeout_released");
      end
      step(idleStim(), zero, "timeout_busy_drop");
      step(s, holdAll, "rewait_hold");
      step(idleStim(), zero, "rewait_release");

      // Reset asserted mid-cycle while in FLUSH.
      s = idleStim(); s.jump = 1'b1; s.jaddr = 32'h8000_0300;
      step(s, mkExp(0, 0, 0, 1, 1, 1, 0, 0, 32'h8000_0300), "jump_before_rst");
      applyStimulus(idleStim(), zero, "rst_in_flush");
      #2 rst = 1'b1;
      checkOutput();
      @(posedge clk);
      #1 rst = 1'b0;
      step(idleStim(), zero, "after_rst_idle");
      s = idleStim(); s.wb = WB_MEM; s.rd = 5'd9; s.rs1 = 5'd9; s.ren1 = 1'b1;
      step(s, bubble, "after_rst_loaduse");

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
